// File: rtl/uart_rx_axis_bridge_pkg.sv
// Shared definitions for the UART receive bridge: parity encoding, receiver
// state encoding and baud-rate divider derivation.
package uart_rx_axis_bridge_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_WAIT_HIGH,
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  function automatic int calc_baud_div(input int clk_rate, input int baud);
    return clk_rate / baud;
  endfunction

  function automatic int calc_half(input int clk_rate, input int baud);
    return (clk_rate / baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_frame.sv
// Serial frame receiver: input synchroniser, bit-timing FSM and parity/stop
// checking. Emits registered one-cycle strobes the cycle after the stop sample.
module uart_rx_frame
  import uart_rx_axis_bridge_pkg::*;
#(
  parameter int CLK_RATE = 50000000,
  parameter int BAUD     = 115200,
  parameter int WIDTH    = 8,
  parameter int PARITY   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_rx,
  output logic             o_done,
  output logic [WIDTH-1:0] o_data,
  output logic             o_parity_err,
  output logic             o_frame_err,
  output logic             o_in_idle
);

  localparam int BAUD_DIV = calc_baud_div(CLK_RATE, BAUD);
  localparam int HALF     = calc_half(CLK_RATE, BAUD);
  localparam int CW       = $clog2(BAUD_DIV + 1);
  localparam int BW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

  logic [1:0]       r_sync;
  rx_state_e        r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [BW-1:0]    r_bitcnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_par;
  logic             r_done, r_parity_err, r_frame_err;

  logic w_rxs, w_tick, w_shift_en, w_par_en, w_stop_en, w_par_bad;

  assign w_rxs = r_sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= 2'b11;
    else     r_sync <= {r_sync[0], i_rx};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_WAIT_HIGH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_WAIT_HIGH: if (w_rxs)  w_next = ST_IDLE;
      ST_IDLE:      if (!w_rxs) w_next = ST_START;
      ST_START:     if (w_tick) w_next = w_rxs ? ST_IDLE : ST_DATA;
      ST_DATA:      if (w_tick && r_bitcnt == BIT_LAST)
                      w_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY:    if (w_tick) w_next = ST_STOP;
      ST_STOP:      if (w_tick) w_next = w_rxs ? ST_IDLE : ST_WAIT_HIGH;
      default:      w_next = ST_WAIT_HIGH;
    endcase
  end

  // Start bit is sampled at its midpoint, every later bit one full period on.
  always_comb begin
    w_tick = 1'b0;
    case (r_state)
      ST_START:                    w_tick = (r_cnt == HALF_LAST);
      ST_DATA, ST_PARITY, ST_STOP: w_tick = (r_cnt == BAUD_LAST);
      default:                     w_tick = 1'b0;
    endcase
    w_shift_en = w_tick && (r_state == ST_DATA);
    w_par_en   = w_tick && (r_state == ST_PARITY);
    w_stop_en  = w_tick && (r_state == ST_STOP);
    o_in_idle  = (r_state == ST_IDLE);
  end

  always_comb begin
    if (PARITY == PAR_EVEN)     w_par_bad = ^{r_shift, r_par};
    else if (PARITY == PAR_ODD) w_par_bad = ~(^{r_shift, r_par});
    else                        w_par_bad = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_bitcnt     <= '0;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_done       <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_cnt <= (w_tick || (w_next != r_state)) ? '0 : r_cnt + 1'b1;
      if (r_state == ST_START)  r_bitcnt <= '0;
      else if (w_shift_en)      r_bitcnt <= r_bitcnt + 1'b1;
      if (w_shift_en) r_shift <= {w_rxs, r_shift[WIDTH-1:1]};
      if (w_par_en)   r_par   <= w_rxs;
      // A low stop bit outranks any parity verdict.
      r_frame_err  <= w_stop_en && !w_rxs;
      r_parity_err <= w_stop_en && w_rxs && w_par_bad;
      r_done       <= w_stop_en && w_rxs && !w_par_bad;
    end
  end

  assign o_done       = r_done;
  assign o_data       = r_shift;
  assign o_parity_err = r_parity_err;
  assign o_frame_err  = r_frame_err;

endmodule

// File: rtl/uart_rx_axis_bridge.sv
// UART receive to AXI-Stream bridge: stages the newest byte, marks tlast after
// an idle gap, and buffers bytes in a first-word-fall-through FIFO.
module uart_rx_axis_bridge
  import uart_rx_axis_bridge_pkg::*;
#(
  parameter int CLK_RATE  = 50000000,
  parameter int BAUD      = 115200,
  parameter int WIDTH     = 8,
  parameter int PARITY    = 1,
  parameter int DEPTH     = 8,
  parameter int IDLE_BITS = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx,
  output logic [WIDTH-1:0]       m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   parity_err,
  output logic                   frame_err,
  output logic                   overrun,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int BAUD_DIV = calc_baud_div(CLK_RATE, BAUD);
  localparam int AW       = $clog2(DEPTH);
  localparam int CW       = $clog2(BAUD_DIV + 1);
  localparam int IBW      = $clog2(IDLE_BITS + 1);
  localparam logic [CW-1:0]  BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [IBW-1:0] IB_LAST   = IBW'(IDLE_BITS - 1);
  localparam logic [AW:0]    FULL_CNT  = (AW+1)'(DEPTH);

  logic             w_done, w_in_idle;
  logic [WIDTH-1:0] w_data;

  uart_rx_frame #(
    .CLK_RATE (CLK_RATE),
    .BAUD     (BAUD),
    .WIDTH    (WIDTH),
    .PARITY   (PARITY)
  ) u_frame (
    .clk          (clk),
    .rst          (rst),
    .i_rx         (rx),
    .o_done       (w_done),
    .o_data       (w_data),
    .o_parity_err (parity_err),
    .o_frame_err  (frame_err),
    .o_in_idle    (w_in_idle)
  );

  logic [WIDTH-1:0] r_stg_data;
  logic             r_stg_valid, r_pend, r_overrun;
  logic [CW-1:0]    r_idle_cyc;
  logic [IBW-1:0]   r_idle_bits;
  logic [WIDTH:0]   r_mem [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [AW:0]      r_count;

  logic w_empty, w_full, w_pop, w_can_acc;
  logic w_push, w_push_last, w_load, w_clr_stg, w_ovr;
  logic w_idle_run, w_idle_wrap, w_idle_hit;
  logic [WIDTH:0] w_head;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FULL_CNT);
  assign w_pop     = !w_empty && m_axis_tready;
  assign w_can_acc = !w_full || w_pop;

  // A staged byte flushed by a new arrival carries last=1 only if the idle
  // gap already elapsed while it waited for FIFO space.
  always_comb begin
    w_push      = 1'b0;
    w_push_last = 1'b0;
    w_load      = 1'b0;
    w_clr_stg   = 1'b0;
    w_ovr       = 1'b0;
    if (w_done) begin
      if (!r_stg_valid) begin
        w_load = 1'b1;
      end else if (w_can_acc) begin
        w_push      = 1'b1;
        w_push_last = r_pend;
        w_load      = 1'b1;
      end else begin
        w_ovr = 1'b1;
      end
    end else if (r_pend && w_can_acc) begin
      w_push      = 1'b1;
      w_push_last = 1'b1;
      w_clr_stg   = 1'b1;
    end
  end

  assign w_idle_run  = w_in_idle && r_stg_valid && !r_pend && !w_done;
  assign w_idle_wrap = w_idle_run && (r_idle_cyc == BAUD_LAST);
  assign w_idle_hit  = w_idle_wrap && (r_idle_bits == IB_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stg_data  <= '0;
      r_stg_valid <= 1'b0;
      r_pend      <= 1'b0;
      r_overrun   <= 1'b0;
      r_idle_cyc  <= '0;
      r_idle_bits <= '0;
    end else begin
      r_overrun <= w_ovr;
      if (w_load) begin
        r_stg_data  <= w_data;
        r_stg_valid <= 1'b1;
        r_pend      <= 1'b0;
      end else if (w_clr_stg) begin
        r_stg_valid <= 1'b0;
        r_pend      <= 1'b0;
      end else if (w_idle_hit) begin
        r_pend <= 1'b1;
      end
      if (!w_idle_run) begin
        r_idle_cyc  <= '0;
        r_idle_bits <= '0;
      end else if (w_idle_wrap) begin
        r_idle_cyc  <= '0;
        r_idle_bits <= r_idle_bits + 1'b1;
      end else begin
        r_idle_cyc <= r_idle_cyc + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= {w_push_last, r_stg_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Unwritten memory is masked so the port reads zero whenever it is empty.
  assign w_head        = r_mem[r_rp];
  assign m_axis_tvalid = !w_empty;
  assign m_axis_tdata  = w_empty ? '0 : w_head[WIDTH-1:0];
  assign m_axis_tlast  = w_empty ? 1'b0 : w_head[WIDTH];
  assign overrun       = r_overrun;
  assign fifo_count    = r_count;

endmodule

// File: tb/tb_uart_rx_axis_bridge.sv
// Directed bench for uart_rx_axis_bridge at a 16-clock bit period, even parity.
module tb_uart_rx_axis_bridge;

  localparam int CLK_RATE  = 1600000;
  localparam int BAUD      = 100000;
  localparam int BD        = 16;
  localparam int WIDTH     = 8;
  localparam int PARITY    = 1;
  localparam int DEPTH     = 8;
  localparam int IDLE_BITS = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       tready = 1'b0;
  logic [7:0] tdata;
  logic       tvalid, tlast, perr, ferr, ovr;
  logic [3:0] fcnt;

  int checks = 0;
  int errors = 0;
  int n_par = 0, n_frm = 0, n_ovr = 0;
  logic [8:0] beats[$];

  always #5 clk = ~clk;

  uart_rx_axis_bridge #(
    .CLK_RATE (CLK_RATE), .BAUD (BAUD), .WIDTH (WIDTH), .PARITY (PARITY),
    .DEPTH (DEPTH), .IDLE_BITS (IDLE_BITS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast),
    .parity_err    (perr),
    .frame_err     (ferr),
    .overrun       (ovr),
    .fifo_count    (fcnt)
  );

  always @(negedge clk) begin
    if (perr) n_par++;
    if (ferr) n_frm++;
    if (ovr)  n_ovr++;
    if (tvalid && tready) beats.push_back({tlast, tdata});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    rx = 1'b0; cyc(BD);
    for (int i = 0; i < 8; i++) begin rx = d[i]; cyc(BD); end
    rx = p; cyc(BD);
    rx = s; cyc(BD);
  endtask

  task automatic send_good(input logic [7:0] d);
    send_frame(d, ^d, 1'b1);
  endtask

  task automatic wait_beats(input int n, input int maxcyc, input string tag);
    int k = 0;
    while (beats.size() < n && k < maxcyc) begin cyc(1); k++; end
    chk(tag, beats.size(), n);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_tvalid"}, tvalid, 0);
    chk({tag, "_tdata"},  tdata,  0);
    chk({tag, "_tlast"},  tlast,  0);
    chk({tag, "_perr"},   perr,   0);
    chk({tag, "_ferr"},   ferr,   0);
    chk({tag, "_ovr"},    ovr,    0);
    chk({tag, "_fcnt"},   fcnt,   0);
  endtask

  initial begin
    cyc(3);
    chk_quiet("reset");
    rst = 1'b0; tready = 1'b1;
    cyc(2 * BD);

    // Single byte: held in staging until the idle gap, then emitted with last.
    send_good(8'hA5);
    cyc(10 * BD);
    chk("t1_no_early_beat", beats.size(), 0);
    chk("t1_no_early_tvalid", tvalid, 0);
    wait_beats(1, 25 * BD, "t1_beat_count");
    chk("t1_beat", beats[0], {1'b1, 8'hA5});
    chk("t1_no_perr", n_par, 0);
    chk("t1_no_ferr", n_frm, 0);

    // Back-to-back: each arrival flushes the previous byte with last=0.
    send_good(8'h01); send_good(8'h02); send_good(8'h03);
    cyc(4);
    chk("t2_two_beats", beats.size(), 3);
    chk("t2_beat01", beats[1], {1'b0, 8'h01});
    chk("t2_beat02", beats[2], {1'b0, 8'h02});
    wait_beats(4, 30 * BD, "t2_beat_count");
    chk("t2_beat03", beats[3], {1'b1, 8'h03});

    // Wrong parity bit (0x07 needs 1 for even parity).
    send_frame(8'h07, 1'b0, 1'b1);
    cyc(4);
    chk("t3_perr_once", n_par, 1);
    cyc(25 * BD);
    chk("t3_perr_still_once", n_par, 1);
    chk("t3_no_beat", beats.size(), 4);
    chk("t3_fcnt", fcnt, 0);
    chk("t3_ferr_none", n_frm, 0);

    // Low stop bit, line held low: no restart until rx returns high.
    send_frame(8'h55, 1'b0, 1'b0);
    cyc(3 * BD);
    chk("t4_ferr_once", n_frm, 1);
    chk("t4_perr_unchanged", n_par, 1);
    rx = 1'b1;
    cyc(2 * BD);
    chk("t4_no_beat", beats.size(), 4);
    send_good(8'h33);
    wait_beats(5, 35 * BD, "t4_beat_count");
    chk("t4_beat33", beats[4], {1'b1, 8'h33});
    chk("t4_ferr_still_once", n_frm, 1);

    // Backpressure: fill FIFO, one overrun, then drain.
    tready = 1'b0;
    for (int i = 0; i < 10; i++) send_good(8'h10 + 8'(i));
    cyc(4);
    chk("t5_fcnt_full", fcnt, 8);
    chk("t5_ovr_once", n_ovr, 1);
    chk("t5_tvalid", tvalid, 1);
    chk("t5_head_data", tdata, 8'h10);
    chk("t5_head_last", tlast, 0);
    cyc(25 * BD);
    chk("t5_fcnt_held", fcnt, 8);
    chk("t5_head_stable", tdata, 8'h10);
    tready = 1'b1;
    wait_beats(14, 40, "t5_beat_count");
    for (int i = 0; i < 8; i++)
      chk($sformatf("t5_beat%0d", i), beats[5 + i], {1'b0, 8'h10 + 8'(i)});
    chk("t5_beat18", beats[13], {1'b1, 8'h18});
    cyc(4);
    chk("t5_fcnt_empty", fcnt, 0);
    chk("t5_ovr_still_once", n_ovr, 1);

    // Glitch shorter than half a bit: false start, nothing reported.
    rx = 1'b0; cyc(5); rx = 1'b1;
    cyc(30 * BD);
    chk("t6_glitch_no_beat", beats.size(), 14);
    chk("t6_glitch_no_perr", n_par, 1);
    chk("t6_glitch_no_ferr", n_frm, 1);

    // Reset mid-DATA with a byte already staged: neither ever appears.
    send_good(8'h42);
    rx = 1'b0; cyc(BD);
    rx = 1'b1; cyc(BD);
    rx = 1'b0; cyc(BD / 2);
    rst = 1'b1;
    cyc(2);
    chk_quiet("t6_rst");
    rx = 1'b1;
    rst = 1'b0;
    cyc(35 * BD);
    chk("t6_after_rst_no_beat", beats.size(), 14);
    chk("t6_after_rst_fcnt", fcnt, 0);
    chk("t6_after_rst_tvalid", tvalid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_axis_bridge.md
Name: uart_rx_axis_bridge

Overview:
UART-to-AXI-Stream receive bridge; the return path that mirrors the existing AXIS→FIFO→UART transmit chain.
- Deserialises 8N1/8E1/8O1 frames from the serial line.
- Drops corrupted bytes and pulses error flags for them.
- Buffers good bytes in a FIFO and presents them on an AXI-Stream master port with backpressure.
- Marks tlast on the final byte before a line-idle gap.

Parameters:
CLK_RATE, 50000000, clk frequency in Hz
BAUD, 115200, bit rate; BAUD_DIV = CLK_RATE/BAUD (integer), HALF = BAUD_DIV/2
WIDTH, 8, data bits per frame
PARITY, 1, 0 none / 1 even / 2 odd
DEPTH, 8, FIFO entries, power of two
IDLE_BITS, 20, idle bit-times after last byte before tlast is generated

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
rx  in  1  asynchronous serial input, idle high
m_axis_tdata  out  WIDTH  received byte
m_axis_tvalid  out  1  byte available
m_axis_tready  in  1  downstream accept
m_axis_tlast  out  1  last byte before idle gap
parity_err  out  1  one-cycle pulse, byte dropped
frame_err  out  1  one-cycle pulse, stop bit low, byte dropped
overrun  out  1  one-cycle pulse, good byte dropped because FIFO full
fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
Reset:
- Every output is 0, including tdata and tlast.
- Synchroniser flops reset to 1; FIFO is emptied; staging register is cleared.
- Receiver enters WAIT_HIGH. Reset mid-frame discards the frame in progress.

Input and receiver FSM:
- rx passes through a 2-flop synchroniser (rxs).
- WAIT_HIGH: go to IDLE when rxs=1.
- IDLE: go to START when rxs=0.
- START: count HALF cycles, then sample. If rxs=1, it is a false start: go to IDLE, no flags. Otherwise go to DATA.
- DATA: sample every BAUD_DIV cycles, WIDTH bits, LSB first.
- PARITY: one bit sample, present only when PARITY≠0.
- STOP: sample after BAUD_DIV cycles.
  - Stop bit 0: pulse frame_err, drop the byte, go to WAIT_HIGH. frame_err takes priority over parity_err.
  - Stop bit 1 with parity mismatch: pulse parity_err, drop the byte, go to IDLE.
  - Stop bit 1, parity good: byte complete, go to IDLE.
- Error pulses assert the cycle after the stop sample.

Staging and tlast:
- The newest good byte is held in a staging register (stg_valid), not written straight to the FIFO.
- Byte completes, stg_valid=0: load staging.
- Byte completes, stg_valid=1, FIFO can accept: push staged byte with last=0, load the new byte into staging.
- Byte completes, stg_valid=1, FIFO cannot accept: new byte dropped, overrun pulses, staging unchanged.
- Idle counter:
  - counts bit-times (BAUD_DIV cycles) while the receiver is in IDLE and stg_valid=1;
  - clears when the receiver leaves IDLE;
  - on reaching IDLE_BITS, a push of the staged byte with last=1 becomes pending.
- The pending push waits until the FIFO can accept, then clears stg_valid.

FIFO and AXIS handshake:
- FIFO stores {last, data} and is first-word-fall-through:
  - tvalid = !empty;
  - tdata/tlast = head entry;
  - a pushed entry is visible on the port the cycle after the push.
- Pop when tvalid && tready. tdata/tlast stay stable while tvalid && !tready.
- FIFO can accept = !full || pop in the same cycle; simultaneous push and pop at full is legal and leaves the count unchanged.
- Pointers wrap modulo DEPTH; the count width is log2(DEPTH)+1.

Decomposition:
Shared package:
- PARITY encoding constants;
- receiver state encoding (WAIT_HIGH, IDLE, START, DATA, PARITY, STOP);
- BAUD_DIV/HALF derivation function.

Sub-module uart_rx_frame holds the synchroniser, FSM and error detection. It outputs a byte-done strobe, data, parity_err, frame_err and an in_idle flag. The top level holds staging, the idle timer, the FIFO and the AXIS port.

Test Plan:
Defaults (BAUD_DIV=434, HALF=217) unless stated; "bit" below means one bit-time.
1. rx frame 0xA5, parity 0, stop 1; tready=1 → nothing on the port until 20 idle bits elapse. Then one beat tdata=0xA5, tlast=1, and no error pulses.
2. Back-to-back 0x01, 0x02, 0x03, tready=1 → beats 0x01 (last=0) and 0x02 (last=0) as each following byte completes. 0x03 (last=1) appears after the 20-bit idle gap.
3. 0x07 sent with parity bit 0 → parity_err pulses once, no beat, fifo_count stays 0.
4. 0x55 sent with stop bit 0, rx held low 3 bits then released → frame_err pulses once, no beat. No new start is detected until rx goes high; a following 0x33 is received correctly.
5. tready=0, send 0x10..0x19 (10 bytes) → fifo_count=8 after 0x19 arrives. 0x19 is dropped with one overrun pulse; staging holds 0x18. Raise tready → beats 0x10..0x17 all with last=0, then 0x18 with last=1.
6. rx low for 100 cycles (<HALF) → no beat, no flags. Separately, assert rst mid-DATA → all outputs 0, fifo_count 0, partial byte never emitted.
